// File: rtl/dr_pkg.sv
// Shared types and codeword constants for the dual-rail receiver.
package dr_pkg;

  typedef enum logic {
    WAIT_DATA   = 1'b0,
    WAIT_SPACER = 1'b1
  } dr_state_t;

  localparam logic [1:0] DR_SPACER  = 2'b00;
  localparam logic [1:0] DR_ZERO    = 2'b01;
  localparam logic [1:0] DR_ONE     = 2'b10;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

endpackage

// File: rtl/dr_rx_sync.sv
// Input capture stage for the dual-rail bus; DR_RX_SYNC_EN selects a
// two-flop synchronizer per rail, otherwise a single register stage.
module dr_rx_sync
  import dr_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

`ifdef DR_RX_SYNC_EN
  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end
`endif

endmodule

// File: rtl/dr_rx.sv
// Dual-rail to synchronous receiver: four-phase ack handshake on the
// asynchronous side, one-word valid/ready buffer on the clocked side.
module dr_rx
  import dr_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*N-1:0] in,
  output logic           ack,
  output logic [N-1:0]   out,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic           err
);

  logic [2*N-1:0] s;
  logic [2*N-1:0] p;
  logic [N-1:0]   pair_valid;
  logic [N-1:0]   pair_spacer;
  logic [N-1:0]   pair_illegal;
  logic [N-1:0]   data;
  logic           stable;
  logic           complete;
  logic           spacer;
  logic           illegal;
  logic           capture;
  logic           err_done;
  dr_state_t      state;

  dr_rx_sync #(.W(2*N)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in),
    .q     (s)
  );

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pair
      logic [1:0] pr;
      assign pr               = s[2*gi+1 -: 2];
      assign pair_valid[gi]   = (pr == DR_ZERO) || (pr == DR_ONE);
      assign pair_spacer[gi]  = (pr == DR_SPACER);
      assign pair_illegal[gi] = (pr == DR_ILLEGAL);
      assign data[gi]         = pr[1];
    end
  endgenerate

  // Only samples that held for two consecutive cycles are acted upon.
  assign stable   = (s == p);
  assign complete = stable && (&pair_valid);
  assign spacer   = stable && (&pair_spacer);
  assign illegal  = stable && (|pair_illegal);
  assign capture  = (state == WAIT_DATA) && complete && (!out_vld || out_rdy);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p        <= '0;
      state    <= WAIT_DATA;
      ack      <= 1'b0;
      out      <= '0;
      out_vld  <= 1'b0;
      err      <= 1'b0;
      err_done <= 1'b0;
    end else begin
      p   <= s;
      err <= illegal && !err_done;
      // err_done re-arms only once the sample has moved.
      if (!stable)      err_done <= 1'b0;
      else if (illegal) err_done <= 1'b1;

      if (capture) begin
        out     <= data;
        out_vld <= 1'b1;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end

      unique case (state)
        WAIT_DATA: begin
          if (capture) begin
            state <= WAIT_SPACER;
            ack   <= 1'b1;
          end
        end
        WAIT_SPACER: begin
          if (spacer) begin
            state <= WAIT_DATA;
            ack   <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_DATA;
          ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dr_rx.md
DR_RX -- requirements
Module: dr_rx

Interface
REQ-001 SHALL have parameter N, default 16: number of data bits, i.e. number of dual-rail pairs.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in, input, 2N bits: asynchronous dual-rail data.
  - Pair i is {in[2i+1], in[2i]}.
  - 2'b01 = bit 0; 2'b10 = bit 1; 2'b00 = spacer; 2'b11 = illegal.
REQ-005 SHALL have port ack, output, 1 bit: acknowledge returned to the dual-rail sender.
REQ-006 SHALL have port out, output, N bits: decoded synchronous data.
REQ-007 SHALL have port out_vld, output, 1 bit: out holds a valid word.
REQ-008 SHALL have port out_rdy, input, 1 bit: downstream accepts the word.
REQ-009 SHALL have port err, output, 1 bit: one-cycle pulse flagging an illegal codeword.

Function
REQ-010 SHALL register in through a synchronizer stage (see Configuration), giving the value S.
REQ-011 SHALL keep a one-cycle-delayed copy P of S; the sample is stable when S==P.
REQ-012 SHALL classify a stable sample as follows:
  - complete: every pair is 01 or 10;
  - spacer: all pairs are 00;
  - illegal: any pair is 11;
  - any other sample is incomplete and is ignored.
REQ-013 SHALL implement a two-state FSM with states WAIT_DATA and WAIT_SPACER; reset state is WAIT_DATA.
REQ-014 In WAIT_DATA, a stable complete sample SHALL be captured when the buffer is free, i.e. out_vld==0 or out_rdy==1.
REQ-015 On capture, at the next edge:
  - out[i] = S[2i+1];
  - out_vld = 1;
  - ack = 1;
  - state moves to WAIT_SPACER.
REQ-016 A stable complete sample with the buffer full and out_rdy=0 SHALL stall in WAIT_DATA, with ack=0 and out unchanged.
REQ-017 In WAIT_SPACER, a stable spacer SHALL clear ack to 0 and return to WAIT_DATA at the next edge; every other sample is ignored.
REQ-018 out_vld SHALL clear at the edge where out_vld&&out_rdy, unless a capture occurs at the same edge; then the new word loads and out_vld stays 1.
REQ-019 out SHALL be stable while out_vld=1 and out_rdy=0.
REQ-020 A stable illegal sample SHALL pulse err for exactly one cycle per stable period, in either state, with no capture and no state change.
REQ-021 Latency SHALL be as follows, where in is stable and complete before edge k and the buffer is free:
  - DR_RX_SYNC_EN defined: out_vld and ack rise after edge k+3;
  - DR_RX_SYNC_EN undefined: they rise after edge k+2.
REQ-022 ack SHALL rise and fall only at clk edges; ack is glitch-free because it comes straight from a register.

Reset
REQ-023 While rst_n=0 at an edge, the block SHALL set:
  - state = WAIT_DATA;
  - ack = 0, out_vld = 0, err = 0;
  - out = 0;
  - all synchronizer and P registers = 0.
REQ-024 Reset mid-handshake SHALL drop ack to 0 and discard the buffered word.
REQ-025 After reset, a stable spacer SHALL NOT be required before the first capture.

Configuration
REQ-026 Macro DR_RX_SYNC_EN defined: S SHALL come from a two-flop synchronizer per rail.
REQ-027 Macro DR_RX_SYNC_EN undefined: S SHALL come from a single register stage.
REQ-028 The macro SHALL affect nothing except latency (REQ-021).

Structure
REQ-029 Shared package dr_pkg SHALL hold:
  - the FSM state typedef (WAIT_DATA, WAIT_SPACER);
  - 2-bit constants DR_SPACER=2'b00, DR_ZERO=2'b01, DR_ONE=2'b10, DR_ILLEGAL=2'b11.
REQ-030 Sub-module dr_rx_sync (parameter W) SHALL implement the synchronizer stage that DR_RX_SYNC_EN selects.
REQ-031 The FSM, classification, buffer and err logic SHALL reside in dr_rx.

Verification (N=4, DR_RX_SYNC_EN defined unless stated)
REQ-032 Basic transfer:
  - Stimulus: in=8'h99, out_rdy=1.
  - Response: out=4'hA, out_vld=1 and ack=1 three edges after in is applied; in=0 -> ack=0 three edges later.
REQ-033 Back-pressure:
  - Stimulus: out_rdy=0; send 8'h66, then spacer, then 8'h99.
  - Response: out=4'h5 is held and ack stays 0 for the second word; raise out_rdy -> 4'hA captured at the same edge as the pop, and out_vld stays 1.
REQ-034 Skew:
  - Stimulus: drive pairs of 8'h99 one per cycle (incomplete intermediate samples).
  - Response: no capture until all four pairs are valid and stable; exactly one word 4'hA is delivered.
REQ-035 Illegal code:
  - Stimulus: in=8'hC9 (pair 3 = 11).
  - Response: exactly one err pulse; out_vld and ack stay 0; state stays WAIT_DATA.
REQ-036 Reset mid-operation:
  - Stimulus: rst_n=0 for one edge while ack=1 and out_vld=1.
  - Response: all outputs 0 after that edge; holding 8'h66 and releasing reset -> capture of 4'h5.
REQ-037 Configuration:
  - Stimulus: DR_RX_SYNC_EN undefined; basic transfer with 8'h99.
  - Response: out_vld rises one edge earlier than in REQ-032; all other behaviour identical.
